// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Indexed [row][column]; column 0 is driven by col[0].
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Index of the lowest-numbered zero bit; used for both row priority and column index.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, with a configurable idle value.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  // NOTE: asynchronous reset belongs in the sensitivity list; every register here gets a reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low column drive, debounced press/release,
// hex key code with a one-cycle strobe and a held level.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_BITS      = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  logic [3:0]           w_row_s;
  logic                 w_tick;
  logic                 w_any;
  logic [1:0]           w_win;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [3:0]           w_col_rot;

  kp_state_t            r_state;
  logic [SCAN_BITS-1:0] r_dcnt;
  logic [CNT_W-1:0]     r_cnt;
  logic [3:0]           r_col;
  logic [1:0]           r_cand_row;
  logic [1:0]           r_cand_col;
  logic [3:0]           r_key_code;
  logic                 r_key_valid;
  logic                 r_key_held;

  // Rows idle high through the pull-ups, so the synchronizer resets to all-ones.
  sync2 #(
    .WIDTH    (4),
    .RESET_VAL(4'hF)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .i_d  (row),
    .o_q  (w_row_s)
  );

  assign w_tick    = &r_dcnt;
  assign w_any     = ~&w_row_s;
  assign w_win     = low_index(w_row_s);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_col_rot = {r_col[2:0], r_col[3]};

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= SCAN;
      r_dcnt      <= '0;
      r_cnt       <= '0;
      r_col       <= COL_RESET;
      r_cand_row  <= 2'd0;
      r_cand_col  <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_dcnt      <= r_dcnt + SCAN_BITS'(1);
      r_key_valid <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          SCAN: begin
            if (w_any) begin
              r_cand_row <= w_win;
              r_cand_col <= low_index(r_col);
              r_cnt      <= CNT_W'(1);
              r_state    <= DEBOUNCE;
            end else begin
              r_col <= w_col_rot;
            end
          end
          DEBOUNCE: begin
            if (w_any && (w_win == r_cand_row)) begin
              if (w_cnt_inc == CNT_DONE) begin
                r_key_code  <= KEY_MAP[r_cand_row][r_cand_col];
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= HELD;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_col   <= w_col_rot;
              r_state <= SCAN;
            end
          end
          HELD: begin
            // Any low row restarts the release count, so other keys are simply ignored here.
            if (w_any) begin
              r_cnt <= '0;
            end else if (w_cnt_inc == CNT_DONE) begin
              r_key_held <= 1'b0;
              r_cnt      <= '0;
              r_col      <= w_col_rot;
              r_state    <= SCAN;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          default: begin
            r_state <= SCAN;
          end
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, table of presses,
// key_valid scoreboard, plus bounce and mid-operation reset sequences.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;   // bit r*4+c set means key (r, c) is pressed
  logic [3:0]  exp_q[$];
  int          total;
  int          bad;

  typedef struct {
    logic [15:0] keys;
    logic [15:0] extra;  // pressed after acceptance; must be ignored
    logic [3:0]  code;
    logic [3:0]  col;
    int          lat;    // cycles from press (just after entering col 1110) to key_valid
  } vec_t;

  vec_t vecs[7];

  keypad_scanner #(
    .SCAN_BITS     (4),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  // Scoreboard: each key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    check("col_one_low", $countones(~col), 1);
    if (!reset && key_valid) begin
      check("valid_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check("valid_code", key_code, exp_q.pop_front());
        check("valid_held", key_held, 1);
      end
    end
  end

  task automatic wait_col_enter(input logic [3:0] target);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      prev = col;
      @(negedge clk);
      if (col == target && prev != target) found = 1'b1;
    end
    check("col_enter", found, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!key_valid && n < 300);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (key_held && n < 300);
  endtask

  task automatic measure_step(output int n);
    logic [3:0] prev;
    prev = col;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (col == prev && n < 100);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_col"}, col, 4'b1110);
    check({tag, "_code"}, key_code, 0);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"}, key_held, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    wait_col_enter(4'b1110);
    keys = v.keys;
    exp_q.push_back(v.code);
    wait_valid(n);
    check("press_latency", n, v.lat);
    keys = keys | v.extra;
    repeat (64) @(negedge clk);
    check("held_col_frozen", col, v.col);
    check("held_level", key_held, 1);
    keys = '0;
    wait_release(n);
    check("release_latency", n, 48);
    check("col_after_release", col, rotl(v.col));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] exp_col;

    total = 0;
    bad   = 0;
    keys  = '0;
    reset = 1'b1;

    vecs[0] = '{keys: 16'h0020, extra: 16'h0000, code: 4'h5, col: 4'b1101, lat: 64};
    vecs[1] = '{keys: 16'h0011, extra: 16'h8000, code: 4'h1, col: 4'b1110, lat: 48};
    vecs[2] = '{keys: 16'h0800, extra: 16'h0000, code: 4'hC, col: 4'b0111, lat: 96};
    vecs[3] = '{keys: 16'h1000, extra: 16'h0000, code: 4'h0, col: 4'b1110, lat: 48};
    vecs[4] = '{keys: 16'h4000, extra: 16'h0000, code: 4'hE, col: 4'b1011, lat: 80};
    vecs[5] = '{keys: 16'h0008, extra: 16'h0000, code: 4'hA, col: 4'b0111, lat: 96};
    vecs[6] = '{keys: 16'h0440, extra: 16'h0000, code: 4'h6, col: 4'b1011, lat: 80};

    // Reset state and idle column rotation.
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    exp_col = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      measure_step(n);
      exp_col = rotl(exp_col);
      check("idle_dwell", n, 16);
      check("idle_col", col, exp_col);
    end

    // Table of presses and releases.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Bounce: 'C' low for exactly one sample.
    wait_col_enter(4'b0111);
    keys = 16'h0800;
    repeat (16) @(negedge clk);
    check("bounce_col_frozen", col, 4'b0111);
    keys = '0;
    repeat (16) @(negedge clk);
    check("bounce_col_resume", col, 4'b1110);
    check("bounce_held", key_held, 0);
    repeat (16) @(negedge clk);
    check("bounce_col_next", col, 4'b1101);

    // Reset one dwell into DEBOUNCE, then a fresh full debounce.
    wait_col_enter(4'b1110);
    keys = 16'h0020;
    repeat (50) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_debounce");
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(4'h5);
    wait_valid(n);
    check("post_reset_latency", n, 64);

    // Reset during HELD.
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_held");
    keys = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    check("idle_after_reset_col", col, 4'b1101);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
